// File: rtl/apb_cfg_regs.sv
// apb_cfg_regs: APB3 completer holding the accelerator configuration/status
// register file. Drives matrix-unit configuration, a one-cycle start pulse,
// busy/done status and a saturating busy-cycle counter.
//
// Optional feature: define APB_PSLVERR_EN to add the PSLVERR output, flagging
// unmapped/misaligned accesses and writes to read-only registers.
//
// Handshake: a transfer is a setup edge (PSEL=1, PENABLE=0 in IDLE) followed
// by one ACCESS cycle with PREADY=1 (zero wait states); writes commit on the
// ACCESS edge only if PSEL, PENABLE and PWRITE are all still high there.
module apb_cfg_regs #(
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32,
    parameter logic [REG_DATAWIDTH-1:0] ID_VALUE = 32'h5450_0001
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_ADDRWIDTH-1:0] PADDR,
    input  logic                     PWRITE,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic [REG_DATAWIDTH-1:0] PWDATA,
    output logic [REG_DATAWIDTH-1:0] PRDATA,
    output logic                     PREADY,
`ifdef APB_PSLVERR_EN
    output logic                     PSLVERR,
`endif
    input  logic                     done_i,
    output logic                     start_o,
    output logic                     busy_o,
    output logic                     accum_en_o,
    output logic [REG_DATAWIDTH-1:0] addr_a_o,
    output logic [REG_DATAWIDTH-1:0] addr_b_o,
    output logic [REG_DATAWIDTH-1:0] addr_c_o,
    output logic [REG_DATAWIDTH-1:0] mat_size_o,
    output logic [0:0]               apb_state
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [REG_ADDRWIDTH-1:0] ADDR_CTRL     = REG_ADDRWIDTH'('h00);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_STATUS   = REG_ADDRWIDTH'('h04);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_A        = REG_ADDRWIDTH'('h08);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_B        = REG_ADDRWIDTH'('h0C);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_C        = REG_ADDRWIDTH'('h10);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_MAT_SIZE = REG_ADDRWIDTH'('h14);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_CYCLES   = REG_ADDRWIDTH'('h18);
    localparam logic [REG_ADDRWIDTH-1:0] ADDR_ID       = REG_ADDRWIDTH'('h1C);

    logic [0:0]               state;
    logic [REG_ADDRWIDTH-1:0] addr_q;
    logic                     write_q;
    logic [REG_DATAWIDTH-1:0] wdata_q;
    logic                     done_q;
    logic [REG_DATAWIDTH-1:0] cycles_q;
    logic [REG_DATAWIDTH-1:0] rd_mux;

    logic setup;
    logic commit;
    logic wr_ctrl;
    logic wr_status;
    logic start_req;
    logic done_evt;

    assign apb_state = state;
    assign PREADY    = (state == ST_ACCESS);
    assign setup     = (state == ST_IDLE) && PSEL && !PENABLE;
    assign commit    = (state == ST_ACCESS) && PSEL && PENABLE && PWRITE && write_q;
    assign wr_ctrl   = commit && (addr_q == ADDR_CTRL);
    assign wr_status = commit && (addr_q == ADDR_STATUS);
    // A START write is only honoured when no operation is in flight.
    assign start_req = wr_ctrl && wdata_q[0] && !busy_o;
    // Completion only counts while an operation is actually running.
    assign done_evt  = done_i && busy_o;

`ifdef APB_PSLVERR_EN
    logic addr_bad;
    logic ro_write;
    assign addr_bad = (addr_q > ADDR_ID) || (addr_q[1:0] != 2'b00);
    assign ro_write = write_q && ((addr_q == ADDR_CYCLES) || (addr_q == ADDR_ID));
    assign PSLVERR  = (state == ST_ACCESS) && (addr_bad || ro_write);
`endif

    // Read mux decoded from the live address so PRDATA can load at the setup edge.
    always_comb begin
        rd_mux = '0;
        case (PADDR)
            ADDR_CTRL:     rd_mux = {{(REG_DATAWIDTH-2){1'b0}}, accum_en_o, 1'b0};
            ADDR_STATUS:   rd_mux = {{(REG_DATAWIDTH-2){1'b0}}, done_q, busy_o};
            ADDR_A:        rd_mux = addr_a_o;
            ADDR_B:        rd_mux = addr_b_o;
            ADDR_C:        rd_mux = addr_c_o;
            ADDR_MAT_SIZE: rd_mux = mat_size_o;
            ADDR_CYCLES:   rd_mux = cycles_q;
            ADDR_ID:       rd_mux = ID_VALUE;
            default:       rd_mux = '0;
        endcase
    end

    // Two-state APB FSM; latches the transfer attributes at the setup edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state   <= ST_ACCESS;
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data is captured at the setup edge and held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PRDATA <= '0;
        end else if (setup && !PWRITE) begin
            PRDATA <= rd_mux;
        end
    end

    // Configuration registers written on the ACCESS edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accum_en_o <= 1'b0;
            addr_a_o   <= '0;
            addr_b_o   <= '0;
            addr_c_o   <= '0;
            mat_size_o <= '0;
        end else if (commit) begin
            case (addr_q)
                ADDR_CTRL:     accum_en_o <= wdata_q[1];
                ADDR_A:        addr_a_o   <= wdata_q;
                ADDR_B:        addr_b_o   <= wdata_q;
                ADDR_C:        addr_c_o   <= wdata_q;
                ADDR_MAT_SIZE: mat_size_o <= wdata_q;
                default: ;
            endcase
        end
    end

    // Start pulse, busy flag and sticky DONE; a completion beats a W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_o <= 1'b0;
            busy_o  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_o <= start_req;
            if (start_req) begin
                busy_o <= 1'b1;
            end else if (done_evt) begin
                busy_o <= 1'b0;
            end
            if (done_evt) begin
                done_q <= 1'b1;
            end else if (wr_status && wdata_q[1]) begin
                done_q <= 1'b0;
            end else if (start_req) begin
                done_q <= 1'b0;
            end
        end
    end

    // Saturating busy-cycle counter, cleared when a new operation starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (start_req) begin
            cycles_q <= '0;
        end else if (busy_o && (cycles_q != '1)) begin
            cycles_q <= cycles_q + REG_DATAWIDTH'(1);
        end
    end

endmodule
